// File: rtl/fifo_memory_responder_pkg.sv
// rtl/fifo_memory_responder_pkg.sv - shared parity helper, latency range check and error-event indices
package fifo_memory_responder_pkg;

    localparam int MAX_WIDTH         = 64;
    localparam int MIN_READ_LATENCY  = 1;
    localparam int MAX_READ_LATENCY  = 4;
    localparam int NUM_ERROR_EVENTS  = 4;

    typedef enum logic [1:0] {
        EVENT_PARITY        = 2'd0,
        EVENT_UNINITIALISED = 2'd1,
        EVENT_WRITE_ADDRESS = 2'd2,
        EVENT_READ_ADDRESS  = 2'd3
    } error_event_e;

    // Callers zero-extend their word to MAX_WIDTH; extra zeros leave even parity unchanged.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

    function automatic int checked_read_latency(input int latency);
        if (latency < MIN_READ_LATENCY) return MIN_READ_LATENCY;
        if (latency > MAX_READ_LATENCY) return MAX_READ_LATENCY;
        return latency;
    endfunction

endpackage

// File: rtl/fifo_memory_responder_read_pipeline.sv
// rtl/fifo_memory_responder_read_pipeline.sv - register chain carrying read data, parity, flags and valid
module fifo_memory_responder_read_pipeline #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_parity,
    input  logic             in_written,
    input  logic             in_in_range,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_written,
    output logic             out_in_range
);

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] parity_q;
    logic [STAGES-1:0] written_q;
    logic [STAGES-1:0] in_range_q;

    // Payload only advances with a valid, so the last stage holds its word between reads.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q    <= '0;
            parity_q   <= '0;
            written_q  <= '0;
            in_range_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0]     <= in_data;
                parity_q[0]   <= in_parity;
                written_q[0]  <= in_written;
                in_range_q[0] <= in_in_range;
            end
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i]     <= data_q[i-1];
                    parity_q[i]   <= parity_q[i-1];
                    written_q[i]  <= written_q[i-1];
                    in_range_q[i] <= in_range_q[i-1];
                end
            end
        end
    end

    assign out_valid    = valid_q[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign out_parity   = parity_q[STAGES-1];
    assign out_written  = written_q[STAGES-1];
    assign out_in_range = in_range_q[STAGES-1];

endmodule

// File: rtl/fifo_memory_responder.sv
// rtl/fifo_memory_responder.sv - checked simple-dual-port memory with parity, written flags and error counter
module fifo_memory_responder
    import fifo_memory_responder_pkg::*;
#(
    parameter int WIDTH             = 8,
    parameter int DEPTH             = 4,
    parameter int DEPTH_LOG2        = $clog2(DEPTH),
    parameter int READ_LATENCY      = 1,
    parameter bit WRITE_FIRST       = 1'b1,
    parameter int ERROR_COUNT_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         memory_write_enable,
    input  logic [DEPTH_LOG2-1:0]        memory_write_address,
    input  logic [WIDTH-1:0]             memory_write_data,
    input  logic                         inject_parity_error,
    input  logic                         memory_read_enable,
    input  logic [DEPTH_LOG2-1:0]        memory_read_address,
    output logic [WIDTH-1:0]             memory_read_data,
    output logic                         memory_read_valid,
    output logic                         parity_error,
    output logic                         uninitialised_read,
    output logic                         address_error,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count
);

    localparam int LATENCY  = checked_read_latency(READ_LATENCY);
    localparam int SUM_BITS = ERROR_COUNT_WIDTH + 1;

    logic [WIDTH:0]   storage [DEPTH];
    logic [DEPTH-1:0] written_flags;

    logic             write_in_range;
    logic             read_in_range;
    logic             write_accept;
    logic             write_parity;
    logic             collision;
    logic [WIDTH-1:0] s0_data;
    logic             s0_parity;
    logic             s0_written;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic             out_written;
    logic             out_in_range;

    logic [1:0]                  address_error_q;
    logic [NUM_ERROR_EVENTS-1:0] events;
    logic [2:0]                  event_total;
    logic [SUM_BITS-1:0]         count_sum;

    assign write_in_range = int'(memory_write_address) < DEPTH;
    assign read_in_range  = int'(memory_read_address) < DEPTH;
    assign write_accept   = memory_write_enable && write_in_range;
    assign write_parity   = even_parity(MAX_WIDTH'(memory_write_data)) ^ inject_parity_error;
    assign collision      = write_accept && memory_read_enable
                            && (memory_write_address == memory_read_address);

    always_ff @(posedge clock) begin
        if (write_accept) begin
            storage[memory_write_address] <= {write_parity, memory_write_data};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            written_flags <= '0;
        end else if (write_accept) begin
            written_flags[memory_write_address] <= 1'b1;
        end
    end

    // Unwritten and out-of-range entries read as zero with zero parity, so they never flag parity.
    always_comb begin
        s0_data    = '0;
        s0_parity  = 1'b0;
        s0_written = 1'b0;
        if (read_in_range) begin
            if (collision && WRITE_FIRST) begin
                s0_data    = memory_write_data;
                s0_parity  = write_parity;
                s0_written = 1'b1;
            end else if (written_flags[memory_read_address]) begin
                {s0_parity, s0_data} = storage[memory_read_address];
                s0_written = 1'b1;
            end
        end
    end

    fifo_memory_responder_read_pipeline #(
        .WIDTH  (WIDTH),
        .STAGES (LATENCY)
    ) u_read_pipeline (
        .clock        (clock),
        .resetn       (resetn),
        .in_valid     (memory_read_enable),
        .in_data      (s0_data),
        .in_parity    (s0_parity),
        .in_written   (s0_written),
        .in_in_range  (read_in_range),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_parity   (out_parity),
        .out_written  (out_written),
        .out_in_range (out_in_range)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            address_error_q <= '0;
        end else begin
            address_error_q <= {memory_read_enable && !read_in_range,
                                memory_write_enable && !write_in_range};
        end
    end

    assign memory_read_valid  = out_valid;
    assign memory_read_data   = out_data;
    assign parity_error       = out_valid && out_in_range && out_written
                                && (even_parity(MAX_WIDTH'(out_data)) != out_parity);
    assign uninitialised_read = out_valid && out_in_range && !out_written;
    assign address_error      = |address_error_q;

    always_comb begin
        events = '0;
        events[EVENT_PARITY]        = parity_error;
        events[EVENT_UNINITIALISED] = uninitialised_read;
        events[EVENT_WRITE_ADDRESS] = address_error_q[0];
        events[EVENT_READ_ADDRESS]  = address_error_q[1];
    end

    assign event_total = 3'($countones(events));
    assign count_sum   = {1'b0, error_count} + SUM_BITS'(event_total);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            error_count <= '0;
        end else if (count_sum[SUM_BITS-1]) begin
            error_count <= '1;
        end else begin
            error_count <= count_sum[ERROR_COUNT_WIDTH-1:0];
        end
    end

endmodule
